// File: rtl/cache_ctrl_fsm_pkg.sv
// Shared types for the CPU-side cache controller: MESI encoding, controller
// states, default ACE wait budget and small decode helpers.
package cache_pkg;

  typedef enum logic [1:0] {
    MESI_I = 2'b00,
    MESI_S = 2'b01,
    MESI_E = 2'b10,
    MESI_M = 2'b11
  } mesi_t;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_LOOKUP    = 4'd1,
    ST_WRITEBACK = 4'd2,
    ST_REFILL    = 4'd3,
    ST_UPGRADE   = 4'd4,
    ST_UPDATE    = 4'd5,
    ST_RESPOND   = 4'd6
  } cache_ctrl_state_t;

  localparam int DEFAULT_ACE_TIMEOUT = 1024;

  // A line in I behaves as a miss even when its tag matches.
  function automatic logic is_miss(input logic hit, input mesi_t st);
    return (!hit) || (st == MESI_I);
  endfunction

  function automatic logic is_wait_state(input cache_ctrl_state_t st);
    return (st == ST_WRITEBACK) || (st == ST_REFILL) || (st == ST_UPGRADE);
  endfunction

endpackage

// File: rtl/cache_ctrl_fsm_ace_wait_timer.sv
// Counts cycles spent waiting on ace_ready; expired flags the last allowed
// wait cycle so the controller can abort in that same cycle.
module ace_wait_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] CNT_MAX = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] cnt_r;

  assign expired = enable && (cnt_r == CNT_MAX);

  // Wait-cycle counter; clear has priority so a new wait starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (enable && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + TO_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/cache_ctrl_fsm.sv
// Blocking, single-outstanding CPU cache controller sequencing lookup,
// victim writeback, refill and upgrade through the ACE controller.
module cache_ctrl_fsm
  import cache_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_ACE_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_req_valid,
  input  logic       cpu_req_we,
  output logic       cpu_req_ready,
  output logic       cpu_resp_valid,
  output logic       cpu_resp_err,
  input  logic       snoop_active,
  input  logic       hit,
  input  logic [1:0] line_state,
  input  logic       rresp_shared,
  input  logic       ace_ready,
  output logic       read_req,
  output logic       write_req,
  output logic       invalid_req,
  output logic       lookup_en,
  output logic       data_wr_en,
  output logic       state_wr_en,
  output logic [1:0] state_wr_val,
  output logic       busy
);

  cache_ctrl_state_t state_r, next_state_s;
  mesi_t             ls_s;
  logic              we_r;
  logic              abort_s;
  logic              expired_s;
  logic              timer_clr_s;
  logic              timer_en_s;
  logic              refill_ld_s;
  logic              rd_r, wr_r, inv_r, upd_r, resp_r, err_r, busy_r;

  assign ls_s          = mesi_t'(line_state);
  assign cpu_req_ready = (state_r == ST_IDLE) && !snoop_active;
  assign lookup_en     = cpu_req_ready && cpu_req_valid;
  assign timer_en_s    = is_wait_state(state_r);
  assign timer_clr_s   = (next_state_s != state_r);
  // Load refill installs the line in the ace_ready cycle, while rresp_shared is valid.
  assign refill_ld_s   = (state_r == ST_REFILL) && ace_ready && !we_r;

  ace_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clr_s),
    .enable  (timer_en_s),
    .expired (expired_s)
  );

  // Next-state decode; ace_ready beats an expiring timer in the same cycle.
  always_comb begin
    next_state_s = state_r;
    abort_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (lookup_en) next_state_s = ST_LOOKUP;
        else           next_state_s = ST_IDLE;
      end
      ST_LOOKUP: begin
        if (!is_miss(hit, ls_s)) begin
          if (!we_r)                next_state_s = ST_RESPOND;
          else if (ls_s == MESI_S)  next_state_s = ST_UPGRADE;
          else                      next_state_s = ST_UPDATE;
        end else if (ls_s == MESI_M) begin
          next_state_s = ST_WRITEBACK;
        end else begin
          next_state_s = ST_REFILL;
        end
      end
      ST_WRITEBACK: begin
        if (ace_ready)      next_state_s = ST_REFILL;
        else if (expired_s) begin next_state_s = ST_RESPOND; abort_s = 1'b1; end
        else                next_state_s = ST_WRITEBACK;
      end
      ST_REFILL: begin
        if (ace_ready) begin
          if (!we_r)             next_state_s = ST_RESPOND;
          else if (rresp_shared) next_state_s = ST_UPGRADE;
          else                   next_state_s = ST_UPDATE;
        end else if (expired_s) begin
          next_state_s = ST_RESPOND;
          abort_s      = 1'b1;
        end else begin
          next_state_s = ST_REFILL;
        end
      end
      ST_UPGRADE: begin
        if (ace_ready)      next_state_s = ST_UPDATE;
        else if (expired_s) begin next_state_s = ST_RESPOND; abort_s = 1'b1; end
        else                next_state_s = ST_UPGRADE;
      end
      ST_UPDATE:  next_state_s = ST_RESPOND;
      ST_RESPOND: next_state_s = ST_IDLE;
      default:    next_state_s = ST_IDLE;
    endcase
  end

  // State register plus Moore outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      we_r    <= 1'b0;
      rd_r    <= 1'b0;
      wr_r    <= 1'b0;
      inv_r   <= 1'b0;
      upd_r   <= 1'b0;
      resp_r  <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      we_r    <= lookup_en ? cpu_req_we : we_r;
      rd_r    <= (next_state_s == ST_REFILL);
      wr_r    <= (next_state_s == ST_WRITEBACK);
      inv_r   <= (next_state_s == ST_UPGRADE);
      upd_r   <= (next_state_s == ST_UPDATE);
      resp_r  <= (next_state_s == ST_RESPOND);
      err_r   <= abort_s;
      busy_r  <= (next_state_s != ST_IDLE);
    end
  end

  // New line state: M after a store, S/E after a load refill, I otherwise.
  always_comb begin
    state_wr_val = MESI_I;
    if (upd_r) begin
      state_wr_val = MESI_M;
    end else if (refill_ld_s) begin
      state_wr_val = rresp_shared ? MESI_S : MESI_E;
    end else begin
      state_wr_val = MESI_I;
    end
  end

  assign read_req       = rd_r;
  assign write_req      = wr_r;
  assign invalid_req    = inv_r;
  assign data_wr_en     = upd_r;
  assign state_wr_en    = upd_r || refill_ld_s;
  assign cpu_resp_valid = resp_r;
  assign cpu_resp_err   = err_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Directed bench for cache_ctrl_fsm with an 8-cycle ACE timeout; each
// transaction is compared against hand-derived latency and output counts.
module tb_cache_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_req_valid = 1'b0, cpu_req_we = 1'b0, cpu_req_ready;
  logic       cpu_resp_valid, cpu_resp_err;
  logic       snoop_active = 1'b0, hit = 1'b0, rresp_shared = 1'b0, ace_ready = 1'b0;
  logic [1:0] line_state = 2'b00;
  logic       read_req, write_req, invalid_req, lookup_en, data_wr_en, state_wr_en, busy;
  logic [1:0] state_wr_val;

  int n_checks = 0;
  int n_pass   = 0;

  localparam int NEVER = -1;

  always #5 clk = ~clk;

  cache_ctrl_fsm #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we), .cpu_req_ready(cpu_req_ready),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_err(cpu_resp_err),
    .snoop_active(snoop_active), .hit(hit), .line_state(line_state),
    .rresp_shared(rresp_shared), .ace_ready(ace_ready),
    .read_req(read_req), .write_req(write_req), .invalid_req(invalid_req),
    .lookup_en(lookup_en), .data_wr_en(data_wr_en), .state_wr_en(state_wr_en),
    .state_wr_val(state_wr_val), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction. *_wait = cycles spent in that wait state before the
  // ace_ready cycle (NEVER = never answer). Expected values are hand-derived.
  task automatic run_txn(input string tag, input logic we, input logic hit_v,
                         input logic [1:0] ls, input logic shared,
                         input int wb_wait, input int rf_wait, input int up_wait,
                         input int exp_lat, input int exp_wr, input int exp_rd,
                         input int exp_inv, input int exp_sw, input logic [1:0] exp_swv,
                         input int exp_dw, input logic exp_err);
    int wb_n = 0, rf_n = 0, up_n = 0;
    int n_wr = 0, n_rd = 0, n_inv = 0, n_sw = 0, n_dw = 0, n_lk = 0, n_ovl = 0;
    int lat = -1;
    logic [1:0] swv = 2'b00;
    logic err = 1'b0;
    bit done = 1'b0;
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    hit           = hit_v;
    line_state    = ls;
    rresp_shared  = shared;
    ace_ready     = 1'b0;
    #1;
    check_eq({tag, ".ready"}, cpu_req_ready, 1'b1);
    check_eq({tag, ".lookup"}, lookup_en, 1'b1);
    tick();
    for (int c = 1; c <= 40 && !done; c++) begin
      ace_ready = 1'b0;
      if (write_req)   begin wb_n++; ace_ready = (wb_n == wb_wait + 1); end
      if (read_req)    begin rf_n++; ace_ready = (rf_n == rf_wait + 1); end
      if (invalid_req) begin up_n++; ace_ready = (up_n == up_wait + 1); end
      #1;
      if ((int'(write_req) + int'(read_req) + int'(invalid_req)) > 1) n_ovl++;
      n_wr  += int'(write_req);
      n_rd  += int'(read_req);
      n_inv += int'(invalid_req);
      n_dw  += int'(data_wr_en);
      n_lk  += int'(lookup_en);
      if (state_wr_en) begin n_sw++; swv = state_wr_val; end
      if (cpu_resp_valid) begin lat = c; err = cpu_resp_err; done = 1'b1; end
      tick();
    end
    cpu_req_valid = 1'b0;
    ace_ready     = 1'b0;
    #1;
    check_eq({tag, ".latency"}, lat, exp_lat);
    check_eq({tag, ".err"}, err, exp_err);
    check_eq({tag, ".write_req_cyc"}, n_wr, exp_wr);
    check_eq({tag, ".read_req_cyc"}, n_rd, exp_rd);
    check_eq({tag, ".invalid_req_cyc"}, n_inv, exp_inv);
    check_eq({tag, ".req_overlap"}, n_ovl, 0);
    check_eq({tag, ".state_wr_cnt"}, n_sw, exp_sw);
    check_eq({tag, ".state_wr_val"}, swv, exp_swv);
    check_eq({tag, ".data_wr_cnt"}, n_dw, exp_dw);
    check_eq({tag, ".relookup"}, n_lk, 0);
    check_eq({tag, ".idle_busy"}, busy, 1'b0);
    check_eq({tag, ".idle_resp"}, cpu_resp_valid, 1'b0);
    check_eq({tag, ".idle_ready"}, cpu_req_ready, 1'b1);
  endtask

  initial begin
    tick();
    tick();
    check_eq("rst.busy", busy, 1'b0);
    check_eq("rst.read_req", read_req, 1'b0);
    check_eq("rst.resp", cpu_resp_valid, 1'b0);
    check_eq("rst.state_wr_en", state_wr_en, 1'b0);
    check_eq("rst.ready", cpu_req_ready, 1'b1);
    rst = 1'b0;
    tick();

    //      tag       we    hit   ls     shr   wb     rf     up     lat wr rd inv sw swv    dw err
    run_txn("ld_hit_E", 1'b0, 1'b1, 2'b10, 1'b0, NEVER, NEVER, NEVER, 2, 0, 0, 0, 0, 2'b00, 0, 1'b0);
    run_txn("st_hit_E", 1'b1, 1'b1, 2'b10, 1'b0, NEVER, NEVER, NEVER, 3, 0, 0, 0, 1, 2'b11, 1, 1'b0);
    run_txn("st_hit_M", 1'b1, 1'b1, 2'b11, 1'b0, NEVER, NEVER, NEVER, 3, 0, 0, 0, 1, 2'b11, 1, 1'b0);
    run_txn("st_hit_S", 1'b1, 1'b1, 2'b01, 1'b0, NEVER, NEVER, 4,     8, 0, 0, 5, 1, 2'b11, 1, 1'b0);
    run_txn("ld_wb_sh", 1'b0, 1'b0, 2'b11, 1'b1, 3,     2,     NEVER, 9, 4, 3, 0, 1, 2'b01, 0, 1'b0);
    run_txn("st_I_sh",  1'b1, 1'b1, 2'b00, 1'b1, NEVER, 0,     0,     5, 0, 1, 1, 1, 2'b11, 1, 1'b0);
    run_txn("st_I_ex",  1'b1, 1'b0, 2'b01, 1'b0, NEVER, 0,     NEVER, 4, 0, 1, 0, 1, 2'b11, 1, 1'b0);
    run_txn("ld_to",    1'b0, 1'b0, 2'b10, 1'b0, NEVER, NEVER, NEVER, 10, 0, 8, 0, 0, 2'b00, 0, 1'b1);
    run_txn("ld_last",  1'b0, 1'b0, 2'b10, 1'b0, NEVER, 7,     NEVER, 10, 0, 8, 0, 1, 2'b10, 0, 1'b0);
    run_txn("wb_to",    1'b1, 1'b0, 2'b11, 1'b0, NEVER, NEVER, NEVER, 10, 8, 0, 0, 0, 2'b00, 0, 1'b1);

    // Snoop in progress blocks acceptance.
    snoop_active  = 1'b1;
    cpu_req_valid = 1'b1;
    #1;
    check_eq("snoop.ready", cpu_req_ready, 1'b0);
    check_eq("snoop.lookup", lookup_en, 1'b0);
    tick();
    check_eq("snoop.busy", busy, 1'b0);
    snoop_active  = 1'b0;
    cpu_req_valid = 1'b0;
    tick();

    // Reset while REFILL is waiting abandons the transaction silently.
    cpu_req_valid = 1'b1;
    cpu_req_we    = 1'b0;
    hit           = 1'b0;
    line_state    = 2'b10;
    tick();
    cpu_req_valid = 1'b0;
    tick();
    tick();
    check_eq("mid.read_req", read_req, 1'b1);
    rst = 1'b1;
    tick();
    check_eq("mid.busy", busy, 1'b0);
    check_eq("mid.read_req_after", read_req, 1'b0);
    check_eq("mid.ready", cpu_req_ready, 1'b1);
    rst = 1'b0;
    begin
      int n_resp = 0;
      for (int i = 0; i < 12; i++) begin
        n_resp += int'(cpu_resp_valid);
        tick();
      end
      check_eq("mid.no_resp", n_resp, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cache_ctrl_fsm.md
Name: cache_ctrl_fsm

Overview:
CPU-side cache controller directly upstream of the ACE controller. Accepts one CPU load/store at a time and evaluates the tag-compare and MESI result from the datapath. Issues read_req (ReadShared), write_req (WriteClean victim writeback) and invalid_req (MakeUnique) to the ACE controller, waits for ace_ready, updates line state/data and returns a CPU response. Blocking and single-outstanding; snoop handling stays in the ACE controller.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles waiting for ace_ready before aborting with error
TO_W, $clog2(TIMEOUT_CYCLES), timeout counter width (derived, not overridden)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
cpu_req_valid  in  1  CPU request valid
cpu_req_we  in  1  1=store, 0=load
cpu_req_ready  out  1  controller can accept a request
cpu_resp_valid  out  1  one-cycle completion pulse
cpu_resp_err  out  1  qualifies cpu_resp_valid; 1=ACE timeout
snoop_active  in  1  ACE controller servicing snoop; blocks new acceptance
hit  in  1  datapath tag match for indexed line (valid in LOOKUP)
line_state  in  2  MESI state of indexed line (mesi_t)
rresp_shared  in  1  IsShared from read response, valid with ace_ready in REFILL
ace_ready  in  1  ACE transaction complete
read_req  out  1  ReadShared request
write_req  out  1  WriteClean request
invalid_req  out  1  MakeUnique request
lookup_en  out  1  latch address/data, start tag read
data_wr_en  out  1  write CPU store data into line
state_wr_en  out  1  write state_wr_val to indexed line
state_wr_val  out  2  new MESI state
busy  out  1  state != IDLE

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE, timeout counter=0, latched we=0. All outputs 0 except cpu_req_ready, which follows IDLE && !snoop_active. Reset mid-transaction abandons it with no response; the ACE controller shares the reset.
- States: IDLE, LOOKUP, WRITEBACK, REFILL, UPGRADE, UPDATE, RESPOND.
- IDLE: cpu_req_ready = !snoop_active. On valid&&ready: lookup_en=1, latch we, go to LOOKUP.
- LOOKUP (1 cycle). Let miss = !hit || line_state==I.
  - Load hit: go to RESPOND.
  - Store hit, state E or M: go to UPDATE.
  - Store hit, state S: go to UPGRADE.
  - Miss with line_state==M (dirty victim): go to WRITEBACK.
  - Otherwise (miss): go to REFILL.
- Request outputs are Moore, level-held. write_req=1 throughout WRITEBACK, read_req throughout REFILL, invalid_req throughout UPGRADE, including the ace_ready cycle; low the cycle after. Never more than one request high at once.
- WRITEBACK: on ace_ready go to REFILL. No state write (refill overwrites).
- REFILL: on ace_ready:
  - Load: state_wr_en=1, state_wr_val = rresp_shared ? S : E; go to RESPOND.
  - Store with rresp_shared=1: go to UPGRADE.
  - Store with rresp_shared=0: go to UPDATE.
- UPGRADE: on ace_ready go to UPDATE.
- UPDATE (1 cycle): data_wr_en=1, state_wr_en=1, state_wr_val=M; go to RESPOND.
- RESPOND (1 cycle): cpu_resp_valid=1; go to IDLE. The next request can be accepted the cycle after RESPOND.
- Latency, accept edge = cycle 0:
  - Load hit: resp in cycle 2.
  - Store hit E/M: resp in cycle 3.
  - Otherwise: +1 cycle per ACE wait state beyond its ace_ready cycle.
- Timeout: counter clears on entry to WRITEBACK/REFILL/UPGRADE and increments each wait cycle. If it reaches TIMEOUT_CYCLES-1 with ace_ready=0: go to RESPOND with cpu_resp_err=1, no state/data write. ace_ready in that same cycle wins (no error).
- ace_ready outside wait states is ignored. snoop_active only gates acceptance in IDLE; it never stalls an in-flight sequence.
- cpu_req_valid while not ready is ignored, not queued.

Decomposition:
- Package cache_pkg: mesi_t (I=2'b00, S=2'b01, E=2'b10, M=2'b11), cache_ctrl_state_t enum (4-bit), DEFAULT_ACE_TIMEOUT=1024.
- Sub-module ace_wait_timer: clear/enable inputs, expired output, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Load, hit=1, line_state=E -> lookup_en at cycle 0, cpu_resp_valid at cycle 2, no req, no state_wr_en.
- Store, hit=1, line_state=S; ace_ready 4 cycles after UPGRADE entry -> invalid_req high 5 cycles. Then UPDATE with data_wr_en=1, state_wr_val=M, then resp.
- Load miss, line_state=M; ace_ready after 3 cycles in WRITEBACK and after 2 cycles in REFILL with rresp_shared=1 -> write_req then read_req, never overlapping; state_wr_val=S; resp err=0.
- Store miss, line_state=I, rresp_shared=1 -> REFILL, UPGRADE (invalid_req), UPDATE state M, resp.
- TIMEOUT_CYCLES=8, read miss, ace_ready never -> resp with cpu_resp_err=1 after 8 REFILL cycles, no state_wr_en. Repeat with ace_ready on the 8th cycle -> err=0.
- snoop_active=1 with cpu_req_valid=1 -> cpu_req_ready=0, no lookup. rst=1 mid-REFILL -> next cycle IDLE, read_req=0, no response.
